// File: rtl/ex_issue_stage_if.sv
// Bundle of decode, forwarding and EX-side signals around the ID/EX issue stage.
// Illegal is present only when ILLEGAL_OP_EN is defined.
interface ex_issue_stage_if;
  logic        hold;
  logic        flush;
  logic        in_valid;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [15:0] imm;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [1:0]  alu_op;
  logic        alu_src;
  logic        reg_dst;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;

  logic        ex_mem_reg_write;
  logic [4:0]  ex_mem_rd;
  logic [31:0] ex_mem_result;
  logic        mem_wb_reg_write;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_result;

  logic [31:0] data1;
  logic [31:0] data2;
  logic [3:0]  control;
  logic [31:0] store_data;
  logic [4:0]  write_reg;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        out_mem_to_reg;
  logic        out_valid;
  logic        stall;
`ifdef ILLEGAL_OP_EN
  logic        illegal;
`endif

  modport slave (
    input  hold, flush, in_valid, rs_data, rt_data, imm, rs, rt, rd, opcode, funct,
           alu_op, alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg,
           ex_mem_reg_write, ex_mem_rd, ex_mem_result,
           mem_wb_reg_write, mem_wb_rd, mem_wb_result,
    output data1, data2, control, store_data, write_reg, out_reg_write,
           out_mem_read, out_mem_write, out_mem_to_reg, out_valid, stall
`ifdef ILLEGAL_OP_EN
          , illegal
`endif
  );

  modport master (
    output hold, flush, in_valid, rs_data, rt_data, imm, rs, rt, rd, opcode, funct,
           alu_op, alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg,
           ex_mem_reg_write, ex_mem_rd, ex_mem_result,
           mem_wb_reg_write, mem_wb_rd, mem_wb_result,
    input  data1, data2, control, store_data, write_reg, out_reg_write,
           out_mem_read, out_mem_write, out_mem_to_reg, out_valid, stall
`ifdef ILLEGAL_OP_EN
          , illegal
`endif
  );
endinterface

// File: rtl/ex_issue_stage.sv
// ID/EX register feeding the ALU: control decode, operand forwarding, load-use bubbles.
// Optional ILLEGAL_OP_EN flags unlisted Funct/Opcode codes and suppresses their writes.
module ex_issue_stage (
  input logic            clk,
  input logic            rst,
  ex_issue_stage_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100,
    ALU_XOR = 4'b1101
  } alu_ctrl_e;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  write_reg;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    alu_ctrl_e   control;
`ifdef ILLEGAL_OP_EN
    logic        illegal;
`endif
  } ex_slot_t;

  ex_slot_t    ex_q, ex_d;
  alu_ctrl_e   ctrl_dec;
  logic        op_listed;
  logic        imm_zext;
  logic        hazard;
  logic        load_bubble;
  logic [31:0] rs_fwd, rt_fwd;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ctrl_dec  = ALU_ADD;
    op_listed = 1'b1;
    case (bus.alu_op)
      2'b00: ctrl_dec = ALU_ADD;
      2'b01: ctrl_dec = ALU_SUB;
      2'b10: begin
        case (bus.funct)
          6'b100000: ctrl_dec = ALU_ADD;
          6'b100010: ctrl_dec = ALU_SUB;
          6'b100100: ctrl_dec = ALU_AND;
          6'b100101: ctrl_dec = ALU_OR;
          6'b100110: ctrl_dec = ALU_XOR;
          6'b100111: ctrl_dec = ALU_NOR;
          6'b101010: ctrl_dec = ALU_SLT;
          default:   op_listed = 1'b0;
        endcase
      end
      default: begin
        case (bus.opcode)
          6'b001000: ctrl_dec = ALU_ADD;
          6'b001100: ctrl_dec = ALU_AND;
          6'b001101: ctrl_dec = ALU_OR;
          6'b001110: ctrl_dec = ALU_XOR;
          6'b001010: ctrl_dec = ALU_SLT;
          default:   op_listed = 1'b0;
        endcase
      end
    endcase
  end

  // andi/ori/xori take a zero-extended immediate; everything else sign-extends.
  assign imm_zext = bus.opcode inside {6'b001100, 6'b001101, 6'b001110};

  assign hazard = ex_q.valid & ex_q.mem_read & (ex_q.write_reg != 5'd0) & bus.in_valid &
                  ((bus.rs == ex_q.write_reg) |
                   ((bus.rt == ex_q.write_reg) & (~bus.alu_src | bus.mem_write)));

  assign load_bubble = bus.flush | hazard | ~bus.in_valid;
  assign bus.stall   = bus.hold | (hazard & ~bus.flush);

  always_comb begin
    ex_d = ex_q;
    if (!bus.hold) begin
      ex_d.rs         = bus.rs;
      ex_d.rt         = bus.rt;
      ex_d.rs_data    = bus.rs_data;
      ex_d.rt_data    = bus.rt_data;
      ex_d.alu_src    = bus.alu_src;
      ex_d.write_reg  = bus.reg_dst ? bus.rd : bus.rt;
      ex_d.imm_ext    = imm_zext ? {16'h0000, bus.imm} : {{16{bus.imm[15]}}, bus.imm};
      ex_d.control    = ctrl_dec;
      ex_d.valid      = ~load_bubble;
      ex_d.reg_write  = ~load_bubble & bus.reg_write;
      ex_d.mem_read   = ~load_bubble & bus.mem_read;
      ex_d.mem_write  = ~load_bubble & bus.mem_write;
      ex_d.mem_to_reg = ~load_bubble & bus.mem_to_reg;
`ifdef ILLEGAL_OP_EN
      ex_d.illegal    = ~load_bubble & ~op_listed;
      if (ex_d.illegal) begin
        ex_d.reg_write = 1'b0;
        ex_d.mem_write = 1'b0;
      end
`endif
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath fields are cleared too, so nothing reads X after reset and Control shows add.
      ex_q         <= '0;
      ex_q.control <= ALU_ADD;
    end else begin
      ex_q <= ex_d;
    end
  end

  // EX/MEM beats MEM/WB; register 0 is never forwarded.
  always_comb begin
    rs_fwd = ex_q.rs_data;
    if (bus.ex_mem_reg_write && bus.ex_mem_rd == ex_q.rs && ex_q.rs != 5'd0)
      rs_fwd = bus.ex_mem_result;
    else if (bus.mem_wb_reg_write && bus.mem_wb_rd == ex_q.rs && ex_q.rs != 5'd0)
      rs_fwd = bus.mem_wb_result;

    rt_fwd = ex_q.rt_data;
    if (bus.ex_mem_reg_write && bus.ex_mem_rd == ex_q.rt && ex_q.rt != 5'd0)
      rt_fwd = bus.ex_mem_result;
    else if (bus.mem_wb_reg_write && bus.mem_wb_rd == ex_q.rt && ex_q.rt != 5'd0)
      rt_fwd = bus.mem_wb_result;
  end

  assign bus.data1          = rs_fwd;
  assign bus.data2          = ex_q.alu_src ? ex_q.imm_ext : rt_fwd;
  assign bus.store_data     = rt_fwd;
  assign bus.control        = ex_q.control;
  assign bus.write_reg      = ex_q.write_reg;
  assign bus.out_valid      = ex_q.valid;
  assign bus.out_reg_write  = ex_q.reg_write;
  assign bus.out_mem_read   = ex_q.mem_read;
  assign bus.out_mem_write  = ex_q.mem_write;
  assign bus.out_mem_to_reg = ex_q.mem_to_reg;
`ifdef ILLEGAL_OP_EN
  assign bus.illegal        = ex_q.valid & ex_q.illegal;
`endif

endmodule
